mem_access_master: RTL and testbench

//  Initiator side of the unified 16-bit memory port, owning memory's

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_port_arb.sv | 27 ++
 rtl/mem_access_master.sv | 159 +++++++++++++++
 tb/tb_mem_access_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the unified memory port initiator.
//   state_t      : sequencing FSM states (IDLE, ACCESS, RESP)
//   PORT_IF/D    : encoding of the served requester
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   CNT_W        : width of the wait-state down-counter (READ_LATENCY 0..15)
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_port_arb.sv
// Two-input priority select between the data and fetch requesters.
//   if_req, d_req : request levels
//   mask_en       : when high, the port named by mask_port may not be granted
//   mask_port     : port excluded while mask_en is high
//   grant         : some port is granted
//   grant_port    : granted port (PORT_D has priority)
module mem_port_arb
    import mem_bus_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic mask_en,
    input  logic mask_port,
    output logic grant,
    output logic grant_port
);

    logic if_ok;
    logic d_ok;

    // Masking the just-served port in RESP is what makes contention alternate.
    assign d_ok       = d_req  && !(mask_en && (mask_port == PORT_D));
    assign if_ok      = if_req && !(mask_en && (mask_port == PORT_IF));
    assign grant      = d_ok || if_ok;
    assign grant_port = d_ok ? PORT_D : PORT_IF;

endmodule

// File: rtl/mem_access_master.sv
// Initiator for the single 16-bit von Neumann memory port. Arbitrates the
// instruction-fetch and data requesters, drives the memory interface with
// registered outputs and returns read data with a one-cycle valid pulse.
// READ_LATENCY adds wait states before memReadData is sampled.
// Ports:
//   clock, resetn                  : clock, synchronous active-low reset
//   ifReq/ifAddr -> ifValid/ifData : fetch requester
//   dReq/dWe/dAddr/dWdata -> dValid/dRdata : data requester (load/store)
//   busy                           : high while in ACCESS
//   memEnable/memWriteEnable/memAddress/memWriteData/memReadData : memory side
module mem_access_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W_DEF,
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic                  ifValid,
    output logic [DATA_WIDTH-1:0] ifData,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWdata,
    output logic                  dValid,
    output logic [DATA_WIDTH-1:0] dRdata,
    output logic                  busy,
    output logic                  memEnable,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam logic [CNT_W-1:0] RL_INIT = CNT_W'(READ_LATENCY);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  served_q, served_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic grant;
    logic grant_port;

    mem_port_arb u_arb (
        .if_req     (ifReq),
        .d_req      (dReq),
        .mask_en    (state_q == RESP),
        .mask_port  (served_q),
        .grant      (grant),
        .grant_port (grant_port)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            served_q   <= PORT_IF;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_data_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            served_q   <= served_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_data_q  <= if_data_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        served_d   = served_q;
        en_d       = en_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_data_d  = if_data_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            // IDLE and RESP share acceptance; in RESP the arbiter masks the
            // port that was just served.
            IDLE, RESP: begin
                if (grant) begin
                    state_d  = ACCESS;
                    cnt_d    = RL_INIT;
                    served_d = grant_port;
                    en_d     = 1'b1;
                    if (grant_port == PORT_D) begin
                        we_d    = dWe;
                        addr_d  = dAddr;
                        wdata_d = dWdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = ifAddr;
                        wdata_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    if (served_q == PORT_D) begin
                        d_valid_d = 1'b1;
                        if (!we_q) d_rdata_d = memReadData;
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = memReadData;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q == ACCESS);
    assign memEnable      = en_q;
    assign memWriteEnable = we_q;
    assign memAddress     = addr_q;
    assign memWriteData   = wdata_q;
    assign ifValid        = if_valid_q;
    assign ifData         = if_data_q;
    assign dValid         = d_valid_q;
    assign dRdata         = d_rdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: one instance with READ_LATENCY=0 and
// one with READ_LATENCY=3, each attached to its own memory model.
module tb_mem_access_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    int          passed = 0;
    int          total  = 0;

    // ---------------- RL=0 instance ----------------
    logic        ifReq, dReq, dWe;
    logic [15:0] ifAddr, dAddr, dWdata;
    logic        ifValid, dValid, busy, memEnable, memWriteEnable;
    logic [15:0] ifData, dRdata, memAddress, memWriteData, memReadData;
    logic [15:0] mem0 [0:65535];

    mem_access_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(0)) dut0 (
        .clock(clk), .resetn(resetn),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifValid(ifValid), .ifData(ifData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dValid(dValid), .dRdata(dRdata), .busy(busy),
        .memEnable(memEnable), .memWriteEnable(memWriteEnable),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(memReadData)
    );

    // ---------------- RL=3 instance ----------------
    logic        ifReq3, dReq3, dWe3;
    logic [15:0] ifAddr3, dAddr3, dWdata3;
    logic        ifValid3, dValid3, busy3, memEnable3, memWriteEnable3;
    logic [15:0] ifData3, dRdata3, memAddress3, memWriteData3, memReadData3;
    logic [15:0] mem3 [0:65535];

    mem_access_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3)) dut3 (
        .clock(clk), .resetn(resetn),
        .ifReq(ifReq3), .ifAddr(ifAddr3), .ifValid(ifValid3), .ifData(ifData3),
        .dReq(dReq3), .dWe(dWe3), .dAddr(dAddr3), .dWdata(dWdata3),
        .dValid(dValid3), .dRdata(dRdata3), .busy(busy3),
        .memEnable(memEnable3), .memWriteEnable(memWriteEnable3),
        .memAddress(memAddress3), .memWriteData(memWriteData3),
        .memReadData(memReadData3)
    );

    // Memory models: combinational read, synchronous write, plus a backdoor
    // preload port so each array has a single writing process.
    logic        bd_we, bd_sel3;
    logic [15:0] bd_addr, bd_data;

    assign memReadData  = mem0[memAddress];
    assign memReadData3 = mem3[memAddress3];

    always @(posedge clk) begin
        if (bd_we && !bd_sel3) mem0[bd_addr] <= bd_data;
        else if (memEnable && memWriteEnable) mem0[memAddress] <= memWriteData;
    end

    always @(posedge clk) begin
        if (bd_we && bd_sel3) mem3[bd_addr] <= bd_data;
        else if (memEnable3 && memWriteEnable3) mem3[memAddress3] <= memWriteData3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic sel3, input logic [15:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_sel3 = sel3; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        resetn = 1'b0;
        bd_we = 1'b0; bd_sel3 = 1'b0; bd_addr = '0; bd_data = '0;
        ifReq = 0; ifAddr = 0; dReq = 0; dWe = 0; dAddr = 0; dWdata = 0;
        ifReq3 = 0; ifAddr3 = 0; dReq3 = 0; dWe3 = 0; dAddr3 = 0; dWdata3 = 0;

        poke(1'b0, 16'h0010, 16'h1111);
        poke(1'b0, 16'h0100, 16'h1234);
        poke(1'b0, 16'hFFFF, 16'hA5A5);
        poke(1'b0, 16'h0000, 16'h7777);
        poke(1'b0, 16'h2000, 16'h0000);
        poke(1'b1, 16'h0300, 16'hCAFE);
        tick();

        // Reset state
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_en",    {31'd0, memEnable}, 32'd0);
        check("rst_valid", {30'd0, ifValid, dValid}, 32'd0);
        check("rst_addr",  {16'd0, memAddress}, 32'd0);

        // Store to 0x0010 interrupted by reset while in ACCESS
        resetn = 1'b1;
        dReq = 1; dWe = 1; dAddr = 16'h0010; dWdata = 16'h5555;
        tick();
        check("st10_access_we", {30'd0, memEnable, memWriteEnable}, 32'd3);
        check("st10_busy",      {31'd0, busy}, 32'd1);
        resetn = 1'b0; dReq = 0; dWe = 0;
        tick();
        check("st10_rst_ctl",  {28'd0, busy, memEnable, memWriteEnable, dValid}, 32'd0);
        check("st10_rst_addr", {memAddress, memWriteData}, 32'd0);
        check("st10_rst_rdata", {dRdata, ifData}, 32'd0);
        resetn = 1'b1;
        tick();

        // Fetch with RL=0: ifReq in cycle k
        ifReq = 1; ifAddr = 16'h0100;
        check("f_k_en", {31'd0, memEnable}, 32'd0);
        tick();
        check("f_k1_en_we", {30'd0, memEnable, memWriteEnable}, 32'd2);
        check("f_k1_addr",  {16'd0, memAddress}, 32'h0100);
        check("f_k1_valid", {31'd0, ifValid}, 32'd0);
        tick();
        check("f_k2_valid", {30'd0, ifValid, dValid}, 32'd2);
        check("f_k2_data",  {16'd0, ifData}, 32'h1234);
        check("f_k2_en",    {31'd0, memEnable}, 32'd0);
        ifReq = 0;
        tick();
        check("f_k3_idle", {29'd0, ifValid, busy, memEnable}, 32'd0);

        // Store 0xBEEF to 0x2000
        dReq = 1; dWe = 1; dAddr = 16'h2000; dWdata = 16'hBEEF;
        tick();
        check("st_we",    {30'd0, memEnable, memWriteEnable}, 32'd3);
        check("st_wdata", {memAddress, memWriteData}, 32'h2000BEEF);
        tick();
        check("st_valid", {31'd0, dValid}, 32'd1);
        check("st_rdata_held", {16'd0, dRdata}, 32'd0);
        dReq = 0; dWe = 0;
        tick();
        check("st_mem", {16'd0, mem0[16'h2000]}, 32'hBEEF);

        // Load back from 0x2000
        dReq = 1; dWe = 0; dAddr = 16'h2000;
        tick();
        check("ld_we", {30'd0, memEnable, memWriteEnable}, 32'd2);
        tick();
        check("ld_valid", {31'd0, dValid}, 32'd1);
        check("ld_rdata", {16'd0, dRdata}, 32'hBEEF);
        dReq = 0;
        tick();

        // Contention: both requesters held, grants alternate D, IF, D
        dReq = 1; dWe = 0; dAddr = 16'h2000; ifReq = 1; ifAddr = 16'h0100;
        tick();
        check("ct1_addr_d", {15'd0, memEnable, memAddress}, 32'h12000);
        tick();
        check("ct2_dvalid", {30'd0, ifValid, dValid}, 32'd1);
        tick();
        check("ct3_addr_if", {15'd0, memEnable, memAddress}, 32'h10100);
        tick();
        check("ct4_ifvalid", {30'd0, ifValid, dValid}, 32'd2);
        check("ct4_ifdata",  {16'd0, ifData}, 32'h1234);
        tick();
        check("ct5_addr_d", {15'd0, memEnable, memAddress}, 32'h12000);
        tick();
        check("ct6_dvalid", {30'd0, ifValid, dValid}, 32'd1);
        dReq = 0; ifReq = 0;
        tick();
        check("ct7_idle", {30'd0, busy, memEnable}, 32'd0);

        // Boundary: fetch from 0xFFFF
        ifReq = 1; ifAddr = 16'hFFFF;
        tick();
        check("bd_addr", {14'd0, memEnable, memWriteEnable, memAddress}, 32'h2FFFF);
        tick();
        check("bd_data", {15'd0, ifValid, ifData}, 32'h1A5A5);
        ifReq = 0;
        tick();
        check("bd_no_wrap_write", {mem0[16'h0000], mem0[16'hFFFF]}, 32'h7777A5A5);

        // Wait states on the RL=3 instance
        ifReq3 = 1; ifAddr3 = 16'h0300;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("rl3_k%0d_en", i), {14'd0, memEnable3, ifValid3, memAddress3}, 32'h20300);
        end
        tick();
        check("rl3_k5_valid", {15'd0, ifValid3, ifData3}, 32'h1CAFE);
        check("rl3_k5_en",    {31'd0, memEnable3}, 32'd0);
        ifReq3 = 0;
        tick();
        check("rl3_k6_idle", {30'd0, ifValid3, busy3}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
